div_seq: RTL and testbench

Parametrised multi-cycle radix-2 restoring divider for the MIPS processor's HI/LO datapath; executes DIV and DIVU. Accepts a start pulse with operands, iterates one quotient bit per enabled clock, applies sign correction, and returns quotient (LO) and remainder (HI) with a one-cycle `done` pulse. Adds configurable width, signed mode, divide-by-zero detection with early completion, and a synchronous abort for exception flush.

---
 rtl/div_seq.sv | 145 ++++++++++++++
 tb/tb_div_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for the HI/LO datapath (DIV/DIVU).
// One quotient bit per enabled clock, sign fix-up in a final cycle, early finish on divide-by-zero.
module div_seq #(
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_en,
   input  logic             module_en,
   input  logic             start_div,
   input  logic             abort,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t           state;
   state_t           next_state;
   logic             accept;
   logic             finish_op;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] dividend_shift;
   logic [WIDTH-1:0] partial_rem;
   logic [WIDTH-1:0] divisor_reg;
   logic             q_neg;
   logic             r_neg;
   logic             zero_flag;
   logic [WIDTH-1:0] dividend_mag;
   logic [WIDTH-1:0] divisor_mag;
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] diff;
   logic             trial_ok;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;

   assign accept = (state == IDLE) & start_div & module_en & clk_en & ~abort;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else if (clk_en) begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (accept) begin
               next_state = (divisor == '0) ? FIX : CALC;
            end
         end
         CALC: begin
            if (abort) begin
               next_state = IDLE;
            end else if (count == CNT_W'(1)) begin
               next_state = FIX;
            end
         end
         FIX:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      ready     = (state == IDLE);
      finish_op = (state == FIX) & ~abort;
   end

   // Operand magnitudes; the most negative value maps onto itself, which the unsigned core handles
   always_comb begin
      dividend_mag = (is_signed & dividend[WIDTH-1]) ? (WIDTH'(0) - dividend) : dividend;
      divisor_mag  = (is_signed & divisor[WIDTH-1])  ? (WIDTH'(0) - divisor)  : divisor;
   end

   // When the trial subtraction fits, the result is below the divisor, so WIDTH bits suffice
   always_comb begin
      shifted  = {partial_rem, dividend_shift[WIDTH-1]};
      trial_ok = (shifted >= {1'b0, divisor_reg});
      diff     = shifted[WIDTH-1:0] - divisor_reg;
   end

   always_comb begin
      if (zero_flag) begin
         q_fix = '1;
         r_fix = dividend_shift;
      end else begin
         q_fix = q_neg ? (WIDTH'(0) - dividend_shift) : dividend_shift;
         r_fix = r_neg ? (WIDTH'(0) - partial_rem)    : partial_rem;
      end
   end

   // Quotient bits enter at the bottom of dividend_shift as dividend bits leave the top
   always_ff @(posedge clk) begin
      if (rst) begin
         count          <= '0;
         dividend_shift <= '0;
         partial_rem    <= '0;
         divisor_reg    <= '0;
         q_neg          <= 1'b0;
         r_neg          <= 1'b0;
         zero_flag      <= 1'b0;
      end else if (clk_en) begin
         if (accept) begin
            count       <= CNT_W'(WIDTH);
            partial_rem <= '0;
            divisor_reg <= divisor_mag;
            q_neg       <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg       <= is_signed & dividend[WIDTH-1];
            zero_flag   <= (divisor == '0);
            dividend_shift <= (divisor == '0) ? dividend : dividend_mag;
         end else if (state == CALC) begin
            count          <= count - CNT_W'(1);
            dividend_shift <= {dividend_shift[WIDTH-2:0], trial_ok};
            partial_rem    <= trial_ok ? diff : shifted[WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (clk_en) begin
         done <= finish_op;
         if (finish_op) begin
            quotient    <= q_fix;
            remainder   <= r_fix;
            div_by_zero <= zero_flag;
         end
      end
   end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: a table of divisions with known results plus
// hand-written sequences for abort, reset, back-to-back, clock-enable and module-enable cases.
module tb_div_seq;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         clk_en;
   logic         module_en;
   logic         start_div;
   logic         abort;
   logic         is_signed;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         ready;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [W-1:0] dd;
      logic [W-1:0] dv;
      logic         sgn;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         z;
      int           lat;
   } vec_t;

   vec_t vecs[12];

   div_seq #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .clk_en      (clk_en),
      .module_en   (module_en),
      .start_div   (start_div),
      .abort       (abort),
      .is_signed   (is_signed),
      .dividend    (dividend),
      .divisor     (divisor),
      .ready       (ready),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [W-1:0] dd, input logic [W-1:0] dv, input logic sgn);
      dividend  = dd;
      divisor   = dv;
      is_signed = sgn;
      start_div = 1'b1;
      tick();
      start_div = 1'b0;
   endtask

   task automatic waitDone(input int budget, output int lat, output logic busy_ok);
      lat     = 0;
      busy_ok = 1'b1;
      while (lat < budget) begin
         tick();
         lat++;
         if (done) break;
         if (ready) busy_ok = 1'b0;
      end
   endtask

   initial begin
      int   lat;
      logic busy_ok;

      vecs[0]  = '{32'd100,      32'd7,          1'b0, 32'd14,       32'd2,        1'b0, 33};
      vecs[1]  = '{32'hFFFFFFF9, 32'd2,          1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33};
      vecs[2]  = '{32'd7,        32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD, 32'd1,        1'b0, 33};
      vecs[3]  = '{32'hFFFFFFFF, 32'd1,          1'b0, 32'hFFFFFFFF, 32'd0,        1'b0, 33};
      vecs[4]  = '{32'h80000000, 32'hFFFFFFFF,   1'b1, 32'h80000000, 32'd0,        1'b0, 33};
      vecs[5]  = '{32'h00001234, 32'd0,          1'b0, 32'hFFFFFFFF, 32'h00001234, 1'b1, 1};
      vecs[6]  = '{32'd100,      32'd7,          1'b0, 32'd14,       32'd2,        1'b0, 33};
      vecs[7]  = '{32'hFFFFFF9C, 32'd0,          1'b1, 32'hFFFFFFFF, 32'hFFFFFF9C, 1'b1, 1};
      vecs[8]  = '{32'hFFFFFFFF, 32'hFFFFFFFF,   1'b0, 32'd1,        32'd0,        1'b0, 33};
      vecs[9]  = '{32'hFFFFFF9C, 32'hFFFFFFF9,   1'b1, 32'd14,       32'hFFFFFFFE, 1'b0, 33};
      vecs[10] = '{32'd5,        32'd10,         1'b0, 32'd0,        32'd5,        1'b0, 33};
      vecs[11] = '{32'h80000000, 32'd3,          1'b0, 32'h2AAAAAAA, 32'd2,        1'b0, 33};

      rst       = 1'b1;
      clk_en    = 1'b1;
      module_en = 1'b1;
      start_div = 1'b0;
      abort     = 1'b0;
      is_signed = 1'b0;
      dividend  = '0;
      divisor   = '0;
      tick();
      tick();
      checkOutput("reset_ready", W'(ready), 32'd1);
      checkOutput("reset_done", W'(done), 32'd0);
      checkOutput("reset_quotient", quotient, 32'd0);
      checkOutput("reset_remainder", remainder, 32'd0);
      checkOutput("reset_dbz", W'(div_by_zero), 32'd0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].dd, vecs[i].dv, vecs[i].sgn);
         checkOutput($sformatf("v%0d_accept_ready", i), W'(ready), 32'd0);
         waitDone(60, lat, busy_ok);
         checkOutput($sformatf("v%0d_latency", i), W'(lat), W'(vecs[i].lat));
         checkOutput($sformatf("v%0d_done", i), W'(done), 32'd1);
         checkOutput($sformatf("v%0d_ready_at_done", i), W'(ready), 32'd1);
         checkOutput($sformatf("v%0d_busy", i), W'(busy_ok), 32'd1);
         checkOutput($sformatf("v%0d_quotient", i), quotient, vecs[i].q);
         checkOutput($sformatf("v%0d_remainder", i), remainder, vecs[i].r);
         checkOutput($sformatf("v%0d_dbz", i), W'(div_by_zero), W'(vecs[i].z));
         tick();
         checkOutput($sformatf("v%0d_done_pulse", i), W'(done), 32'd0);
      end

      // Abort mid-CALC: no done, previous results kept
      applyStimulus(32'd100, 32'd7, 1'b0);
      for (int k = 0; k < 9; k++) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checkOutput("abort_ready", W'(ready), 32'd1);
      checkOutput("abort_done", W'(done), 32'd0);
      checkOutput("abort_quotient", quotient, 32'h2AAAAAAA);
      checkOutput("abort_remainder", remainder, 32'd2);
      waitDone(40, lat, busy_ok);
      checkOutput("abort_no_done", W'(done), 32'd0);

      // Reset mid-CALC clears everything
      applyStimulus(32'd100, 32'd7, 1'b0);
      for (int k = 0; k < 9; k++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("midrst_ready", W'(ready), 32'd1);
      checkOutput("midrst_done", W'(done), 32'd0);
      checkOutput("midrst_quotient", quotient, 32'd0);
      checkOutput("midrst_remainder", remainder, 32'd0);

      // Back-to-back: second start issued in the done cycle
      applyStimulus(32'd100, 32'd7, 1'b0);
      waitDone(60, lat, busy_ok);
      checkOutput("b2b_first_q", quotient, 32'd14);
      applyStimulus(32'd7, 32'hFFFFFFFE, 1'b1);
      checkOutput("b2b_accept_ready", W'(ready), 32'd0);
      waitDone(60, lat, busy_ok);
      checkOutput("b2b_latency", W'(lat), 32'd33);
      checkOutput("b2b_quotient", quotient, 32'hFFFFFFFD);
      checkOutput("b2b_remainder", remainder, 32'd1);

      // done stretches while clk_en is low
      clk_en = 1'b0;
      tick();
      tick();
      checkOutput("stretch_done_held", W'(done), 32'd1);
      clk_en = 1'b1;
      tick();
      checkOutput("stretch_done_drop", W'(done), 32'd0);

      // clk_en low for 5 cycles mid-CALC delays done by exactly 5
      applyStimulus(32'd1000, 32'd7, 1'b0);
      for (int k = 0; k < 9; k++) tick();
      clk_en = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      clk_en = 1'b1;
      waitDone(60, lat, busy_ok);
      checkOutput("clken_latency", W'(lat + 14), 32'd38);
      checkOutput("clken_quotient", quotient, 32'd142);
      checkOutput("clken_remainder", remainder, 32'd6);
      tick();

      // module_en low: start ignored
      module_en = 1'b0;
      applyStimulus(32'd100, 32'd7, 1'b0);
      checkOutput("modoff_ready", W'(ready), 32'd1);
      waitDone(40, lat, busy_ok);
      checkOutput("modoff_no_done", W'(done), 32'd0);
      checkOutput("modoff_quotient", quotient, 32'd142);
      module_en = 1'b1;

      // abort together with start in IDLE: start ignored
      abort = 1'b1;
      applyStimulus(32'd100, 32'd7, 1'b0);
      abort = 1'b0;
      checkOutput("abort_start_ready", W'(ready), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
